// File: rtl/rf_sb_pkg.sv
// Shared sizing and helpers for the register-file scoreboard.
// Also imported by the RF bench for NUM_REGS and SEL_W.
package rf_sb_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  typedef logic [SEL_W-1:0]    reg_sel_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;

  // One-hot decode of a register select, gated by an enable.
  function automatic reg_vec_t sel_onehot(input logic en, input reg_sel_t sel);
    reg_vec_t v;
    v = '0;
    if (en) v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_sb_counter.sv
// Per-register in-flight write counter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear (flush), wins over inc/dec
//   inc, dec  : one write issued / one write retired this cycle
//   count     : current in-flight count
//   nz        : count != 0
module rf_sb_counter
  import rf_sb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output cnt_t count,
  output logic nz
);

  cnt_t count_q;

  // inc and dec together cancel; the issuer guarantees no wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc && !dec) begin
      count_q <= count_q + cnt_t'(1);
    end else if (dec && !inc) begin
      count_q <= count_q - cnt_t'(1);
    end
  end

  assign count = count_q;
  assign nz    = |count_q;

endmodule

// File: rtl/rf_scoreboard.sv
// Decode-stage hazard tracker in front of the bypassing register file.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   issueValid/issueWrEn/issueWrSel : issuing instruction and its destination
//   src1Used/src1Sel, src2Used/src2Sel : source operands
//   wbEn/wbSel                  : RF write strobe being snooped
//   flush                       : squash all in-flight writes
//   stall                       : combinational hold of the current issue
//   pendingMask                 : per-register "write in flight" (from flops)
//   err                         : sticky, writeback to a register with none pending
module rf_scoreboard
  import rf_sb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           issueValid,
  input  logic           issueWrEn,
  input  logic [SEL_W-1:0] issueWrSel,
  input  logic           src1Used,
  input  logic [SEL_W-1:0] src1Sel,
  input  logic           src2Used,
  input  logic [SEL_W-1:0] src2Sel,
  input  logic           wbEn,
  input  logic [SEL_W-1:0] wbSel,
  input  logic           flush,
  output logic           stall,
  output logic [NUM_REGS-1:0] pendingMask,
  output logic           err
);

  cnt_t     count [NUM_REGS];
  reg_vec_t nz;
  reg_vec_t inc_vec;
  reg_vec_t dec_vec;

  logic src1_busy;
  logic src2_busy;
  logic sat;
  logic accept;
  logic err_q;

  // A source is clear if its last pending write retires this cycle,
  // since the RF bypasses that write onto the read port.
  always_comb begin
    src1_busy = nz[src1Sel] &&
                !(wbEn && (wbSel == src1Sel) && (count[src1Sel] == cnt_t'(1)));
    src2_busy = nz[src2Sel] &&
                !(wbEn && (wbSel == src2Sel) && (count[src2Sel] == cnt_t'(1)));
    sat       = issueWrEn && (count[issueWrSel] == cnt_t'(CNT_MAX)) &&
                !(wbEn && (wbSel == issueWrSel));
  end

  // Hazard check uses pre-issue counts only, so an instruction never
  // stalls on its own destination write.
  assign stall  = issueValid && !rst && !flush &&
                  ((src1Used && src1_busy) || (src2Used && src2_busy) || sat);
  assign accept = issueValid && !stall && !rst && !flush;

  assign inc_vec = sel_onehot(accept && issueWrEn, issueWrSel);
  assign dec_vec = sel_onehot(wbEn, wbSel) & nz;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    rf_sb_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .inc   (inc_vec[r]),
      .dec   (dec_vec[r]),
      .count (count[r]),
      .nz    (nz[r])
    );
  end

  // Writeback with nothing pending is an error unless it is being flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (wbEn && !flush && !nz[wbSel]) begin
      err_q <= 1'b1;
    end
  end

  assign pendingMask = nz;
  assign err         = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios followed by
// randomized co-simulation against an integer-array reference model.
module tb_rf_scoreboard;
  import rf_sb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issueValid = 1'b0, issueWrEn = 1'b0;
  logic [SEL_W-1:0] issueWrSel = '0;
  logic src1Used = 1'b0, src2Used = 1'b0;
  logic [SEL_W-1:0] src1Sel = '0, src2Sel = '0;
  logic wbEn = 1'b0;
  logic [SEL_W-1:0] wbSel = '0;
  logic flush = 1'b0;
  logic stall;
  logic [NUM_REGS-1:0] pendingMask;
  logic err;

  rf_scoreboard dut (
    .clk(clk), .rst(rst),
    .issueValid(issueValid), .issueWrEn(issueWrEn), .issueWrSel(issueWrSel),
    .src1Used(src1Used), .src1Sel(src1Sel),
    .src2Used(src2Used), .src2Sel(src2Sel),
    .wbEn(wbEn), .wbSel(wbSel), .flush(flush),
    .stall(stall), .pendingMask(pendingMask), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: in-flight write count per register and sticky error.
  int m_cnt [NUM_REGS];
  bit m_err = 1'b0;
  logic obs_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < NUM_REGS; i++) if (m_cnt[i] > 0) m[i] = 1'b1;
    return m;
  endfunction

  // A read waits for an outstanding write, unless that is the last one and
  // it lands on the RF this very cycle.
  function automatic bit m_busy(input int s, input bit wb, input int ws);
    return (m_cnt[s] > 0) && !(wb && ws == s && m_cnt[s] == 1);
  endfunction

  // One cycle: drive, check stall, clock, update model, check registered outputs.
  task automatic step(input bit r_i, input bit iv, input bit wr, input int ws,
                      input bit u1, input int s1, input bit u2, input int s2,
                      input bit wb, input int wsel, input bit fl);
    bit exp_stall, acc, sat;
    rst = r_i; issueValid = iv; issueWrEn = wr; issueWrSel = SEL_W'(ws);
    src1Used = u1; src1Sel = SEL_W'(s1); src2Used = u2; src2Sel = SEL_W'(s2);
    wbEn = wb; wbSel = SEL_W'(wsel); flush = fl;
    #1;
    sat = wr && m_cnt[ws] == int'(CNT_MAX) && !(wb && wsel == ws);
    exp_stall = iv && !r_i && !fl &&
                ((u1 && m_busy(s1, wb, wsel)) || (u2 && m_busy(s2, wb, wsel)) || sat);
    acc = iv && !exp_stall && !r_i && !fl;
    obs_stall = stall;
    chk("stall", 32'(stall), 32'(exp_stall));
    @(posedge clk);
    if (r_i) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 1'b0;
    end else if (fl) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      if (wb) begin
        if (m_cnt[wsel] == 0) m_err = 1'b1;
        else m_cnt[wsel]--;
      end
      if (acc && wr) m_cnt[ws]++;
    end
    #1;
    chk("pendingMask", 32'(pendingMask), m_mask());
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle(input bit r_i);
    step(r_i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    @(posedge clk); #1;

    // 1. Reset and idle.
    idle(1); idle(1); idle(0);
    chk("t1_mask", 32'(pendingMask), 32'h00);
    chk("t1_err", 32'(err), 32'h0);

    // 2. RAW stall released by a same-cycle writeback.
    step(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("t2_stall", 32'(obs_stall), 32'h1);
    chk("t2_mask", 32'(pendingMask), 32'h08);
    step(0, 1, 0, 0, 1, 3, 0, 0, 1, 3, 0);
    chk("t2_release", 32'(obs_stall), 32'h0);
    chk("t2_mask_clr", 32'(pendingMask), 32'h00);

    // 3. Issue and writeback to the same register cancel.
    step(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
    chk("t3_stall", 32'(obs_stall), 32'h0);
    chk("t3_mask", 32'(pendingMask), 32'h20);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // 4. Saturation at three in-flight writes.
    repeat (3) step(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_sat_stall", 32'(obs_stall), 32'h1);
    step(0, 1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
    chk("t4_sat_wb", 32'(obs_stall), 32'h0);
    chk("t4_mask", 32'(pendingMask), 32'h80);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // 5. Spurious writeback, then flush over an issue.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    chk("t5_err", 32'(err), 32'h1);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_mask", 32'(pendingMask), 32'h12);
    step(0, 1, 1, 6, 1, 1, 1, 4, 1, 1, 1);
    chk("t5_flush_stall", 32'(obs_stall), 32'h0);
    chk("t5_flush_mask", 32'(pendingMask), 32'h00);
    chk("t5_err_sticky", 32'(err), 32'h1);

    // 6. Random co-simulation.
    idle(1); idle(1);
    for (int c = 0; c < 1000; c++) begin
      int pend [$];
      int wsel;
      bit r_i;
      pend.delete();
      foreach (m_cnt[i]) if (m_cnt[i] > 0) pend.push_back(i);
      if (pend.size() > 0 && $urandom_range(9) != 0)
        wsel = pend[$urandom_range(pend.size() - 1)];
      else
        wsel = int'($urandom_range(NUM_REGS - 1));
      r_i = ($urandom_range(199) == 0);
      step(r_i,
           $urandom_range(9) < 7, $urandom_range(9) < 6, int'($urandom_range(7)),
           $urandom_range(1) == 1, int'($urandom_range(7)),
           $urandom_range(1) == 1, int'($urandom_range(7)),
           $urandom_range(9) < 5, wsel,
           $urandom_range(49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
